// File: rtl/mem_port_arbiter_3_if.sv
// Handshake bundle between the three memory requesters and the port arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface mem_port_arbiter_3_if;
    logic [2:0] req_i;
    logic [2:0] done_i;
    logic [2:0] gnt_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  gnt_o,
        input  sel_o,
        input  busy_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output gnt_o,
        output sel_o,
        output busy_o,
        output timeout_o
    );
endinterface

// File: rtl/mem_port_arbiter_3.sv
// Round-robin arbiter sharing one data-memory port among three requesters.
// A grant is held until the owner strobes done_i, and there is always one idle
// cycle between grants. sel_o keeps the last owner while idle, so it never reads 3.
// Optional hold-time watchdog: define ARB_TIMEOUT_EN to enable it.
module mem_port_arbiter_3 #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_3_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_n;
    logic [2:0] gnt_q, gnt_n;
    logic [1:0] sel_q, sel_n;
    logic [1:0] last_q, last_n;
    logic       timeout_q, timeout_n;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Parameter sanity guard: an illegal HOLD_MAX/CNT_W pairing elaborates this empty block.
    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_n;
`endif

    // Round-robin winner: scan (last+1), (last+2), (last) modulo 3.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last_q) + k) % 3);
            if (!win_found && bus.req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        sel_n     = sel_q;
        last_n    = last_q;
        timeout_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_n = GRANT;
                    gnt_n   = 3'b001 << win_idx;
                    sel_n   = win_idx;
                    last_n  = win_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            GRANT: begin
                // done_i wins over a coincident watchdog expiry.
                if (bus.done_i[sel_q]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_LAST) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    timeout_n = 1'b1;
                end else if (cnt_q < HOLD_SAT) begin
                    cnt_n = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= 2'd0;
            last_q    <= 2'd2;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            sel_q     <= sel_n;
            last_q    <= last_n;
            timeout_q <= timeout_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: cleared on grant entry, counts GRANT cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_n;
    end
    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.gnt_o  = gnt_q;
    assign bus.sel_o  = sel_q;
    assign bus.busy_o = |gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter_3.sv
// Randomized plus directed bench for mem_port_arbiter_3 against an integer-level
// reference model of the round-robin / hold / watchdog rules.
module tb_mem_port_arbiter_3;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    mem_port_arbiter_3_if bus_if();

    mem_port_arbiter_3 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owner -1 means idle, hold counts GRANT cycles so far.
    int m_owner = -1;
    int m_last  = 2;
    int m_sel   = 0;
    int m_hold  = 0;
    int m_to    = 0;

    int grant_log[$];
    logic [2:0] prev_gnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [2:0] r, input logic [2:0] d, input logic rs);
        if (rs) begin
            m_owner = -1; m_last = 2; m_sel = 0; m_hold = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (r[c]) begin
                    m_owner = c; m_last = c; m_sel = c; m_hold = 1;
                    break;
                end
            end
        end else if (d[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold == HOLD) begin
            m_owner = -1;
            m_to = 1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic tick(input logic [2:0] r, input logic [2:0] d, input logic rs);
        logic [2:0] exp_gnt;
        @(negedge clk);
        bus_if.req_i  = r;
        bus_if.done_i = d;
        rst = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
        exp_gnt = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        check_eq("gnt",     32'(bus_if.gnt_o),     32'(exp_gnt));
        check_eq("sel",     32'(bus_if.sel_o),     32'(m_sel));
        check_eq("busy",    32'(bus_if.busy_o),    32'(m_owner >= 0));
        check_eq("timeout", 32'(bus_if.timeout_o), 32'(m_to));
        if (prev_gnt == 3'b000 && bus_if.gnt_o != 3'b000)
            grant_log.push_back(int'(bus_if.sel_o));
        prev_gnt = bus_if.gnt_o;
    endtask

    function automatic logic [2:0] owner_done_at(input int hold_when);
        if (m_owner >= 0 && m_hold == hold_when) return 3'b001 << m_owner;
        return 3'b000;
    endfunction

    initial begin
        bus_if.req_i  = '0;
        bus_if.done_i = '0;
        rst = 1'b1;

        // Reset state, then all three requesting, each owner done 2 cycles after grant.
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b000, 3'b000, 1'b1);
        grant_log.delete();
        for (int i = 0; i < 12; i++) tick(3'b111, owner_done_at(2), 1'b0);
        check_eq("rr_count", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            check_eq("rr_order0", 32'(grant_log[0]), 32'd0);
            check_eq("rr_order1", 32'(grant_log[1]), 32'd1);
            check_eq("rr_order2", 32'(grant_log[2]), 32'd2);
            check_eq("rr_order3", 32'(grant_log[3]), 32'd0);
        end

        // Idle with sel=2, then requester 1 alone; non-owner done ignored.
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b100, 3'b000, 1'b0);
        tick(3'b000, 3'b100, 1'b0);
        tick(3'b000, 3'b000, 1'b0);
        check_eq("idle_sel2", 32'(bus_if.sel_o), 32'd2);
        tick(3'b010, 3'b000, 1'b0);
        check_eq("req1_gnt", 32'(bus_if.gnt_o), 32'b010);
        tick(3'b010, 3'b001, 1'b0);
        tick(3'b010, 3'b001, 1'b0);
        tick(3'b010, 3'b010, 1'b0);
        check_eq("req1_rel", 32'(bus_if.gnt_o), 32'b000);

        // Owner 0 drops req mid-grant: grant persists until done_i[0].
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b001, 3'b000, 1'b0);
        tick(3'b000, 3'b000, 1'b0);
        tick(3'b000, 3'b000, 1'b0);
        check_eq("drop_req_hold", 32'(bus_if.gnt_o), 32'b001);
        tick(3'b000, 3'b001, 1'b0);

        // Owner 1 never done, requester 0 pending: watchdog (if built) then 0 wins.
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b010, 3'b000, 1'b0);
        for (int i = 0; i < 8; i++) tick(3'b011, 3'b000, 1'b0);

        // Reset during an active grant to requester 2, then 101 -> 0 wins.
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b100, 3'b000, 1'b0);
        tick(3'b100, 3'b000, 1'b0);
        tick(3'b100, 3'b000, 1'b1);
        check_eq("rst_gnt", 32'(bus_if.gnt_o), 32'd0);
        check_eq("rst_sel", 32'(bus_if.sel_o), 32'd0);
        tick(3'b101, 3'b000, 1'b0);
        check_eq("post_rst_win", 32'(bus_if.gnt_o), 32'b001);

        // done_i in the same cycle as expiry: normal release, no timeout.
        tick(3'b000, 3'b000, 1'b1);
        tick(3'b001, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) tick(3'b001, owner_done_at(HOLD), 1'b0);
        tick(3'b000, 3'b000, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] r, d;
            logic rs;
            r  = 3'($urandom);
            d  = 3'($urandom) & 3'($urandom) & 3'($urandom);
            rs = ($urandom_range(0, 99) == 0);
            tick(r, d, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
